// File: rtl/mipi_csi_packet_decoder_v2_pkg.sv
// Shared constants and types for the CSI-2 packet decoder.
// Data types, default sync byte, decoder states and the byte mask helper.
package mipi_csi_pkg;

    localparam logic [5:0] DT_FS    = 6'h00;
    localparam logic [5:0] DT_FE    = 6'h01;
    localparam logic [5:0] DT_RAW8  = 6'h2A;
    localparam logic [5:0] DT_RAW10 = 6'h2B;
    localparam logic [5:0] DT_RAW12 = 6'h2C;
    localparam logic [5:0] DT_RAW14 = 6'h2D;

    // Data types below this value are short packets
    localparam logic [5:0] DT_LONG_MIN = 6'h10;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hB8;

    localparam logic [63:0] DT_ENABLE_DEF = (64'd1 << DT_RAW10)
                                          | (64'd1 << DT_RAW12)
                                          | (64'd1 << DT_RAW14);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_HDR,
        ST_PAYLOAD,
        ST_SKIP
    } state_t;

    // Byte enables for the final word; a zero remainder means a full word
    function automatic logic [3:0] byte_mask(input logic [1:0] rem);
        logic [3:0] m;
        m = 4'hF;
        case (rem)
            2'd1:    m = 4'b0001;
            2'd2:    m = 4'b0011;
            2'd3:    m = 4'b0111;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mipi_csi_packet_decoder_v2_if.sv
// Byte-stream bus between the lane aligner, the decoder and the depacker.
// master drives the aligned bytes; slave is the decoder side.
interface mipi_csi_packet_decoder_v2_if #(
    parameter int LANES = 4
);

    logic                 data_valid_i;
    logic [8*LANES-1:0]   data_i;
    logic                 output_valid_o;
    logic [8*LANES-1:0]   data_o;
    logic [LANES-1:0]     byte_en_o;
    logic                 packet_end_o;
    logic [15:0]          packet_length_o;
    logic [5:0]           packet_type_o;
    logic [1:0]           vc_o;
    logic                 frame_start_o;
    logic                 frame_end_o;
    logic                 err_truncated_o;

    modport master (
        output data_valid_i,
        output data_i,
        input  output_valid_o,
        input  data_o,
        input  byte_en_o,
        input  packet_end_o,
        input  packet_length_o,
        input  packet_type_o,
        input  vc_o,
        input  frame_start_o,
        input  frame_end_o,
        input  err_truncated_o
    );

    modport slave (
        input  data_valid_i,
        input  data_i,
        output output_valid_o,
        output data_o,
        output byte_en_o,
        output packet_end_o,
        output packet_length_o,
        output packet_type_o,
        output vc_o,
        output frame_start_o,
        output frame_end_o,
        output err_truncated_o
    );

endinterface

// File: rtl/mipi_csi_packet_decoder_v2_header_assembler.sv
// Collects the 4-byte CSI-2 packet header from 1, 2 or 4 byte lanes.
// header_valid strobes combinationally on the word that completes it.
module mipi_csi_header_assembler
    import mipi_csi_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               en,
    input  logic [8*LANES-1:0] data,
    output logic               header_valid,
    output logic [1:0]         vc,
    output logic [5:0]         dt,
    output logic [15:0]        wc,
    output logic [7:0]         ecc
);

    localparam int         WORDS = 4 / LANES;
    localparam logic [1:0] LAST  = 2'(WORDS - 1);

    logic [1:0]  cnt;
    logic [31:0] hdr;

    assign header_valid = en && (cnt == LAST);

    if (LANES == 4) begin : g_single
        assign hdr = data;
    end else begin : g_shift
        logic [31-8*LANES:0] buf_q;

        // Newest word enters at the top so byte0 ends up lowest
        assign hdr = {data, buf_q};

        // Keep the earlier header bytes until the last word arrives
        always_ff @(posedge clk) begin
            if (reset || clear || header_valid) begin
                buf_q <= '0;
            end else if (en) begin
                buf_q <= hdr[31:8*LANES];
            end
        end
    end

    // Count header words; wraps to zero once the header completes
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= 2'd0;
        end else if (en) begin
            cnt <= header_valid ? 2'd0 : cnt + 2'd1;
        end
    end

    assign vc  = hdr[7:6];
    assign dt  = hdr[5:0];
    assign wc  = hdr[23:8];
    assign ecc = hdr[31:24];

endmodule

// File: rtl/mipi_csi_packet_decoder_v2.sv
// CSI-2 packet stripper: sync hunt, header decode, VC/DT filter,
// payload forwarding with byte enables, FS/FE pulses, truncation flag.
module mipi_csi_packet_decoder_v2
    import mipi_csi_pkg::*;
#(
    parameter int          LANES     = 4,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
    parameter logic [63:0] DT_ENABLE = DT_ENABLE_DEF,
    parameter logic [3:0]  VC_ENABLE = 4'hF
) (
    input logic clk_i,
    input logic reset_i,
    mipi_csi_packet_decoder_v2_if.slave bus
);

    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
        $error("LANES must be 1, 2 or 4");
    end

    state_t             state;
    logic [15:0]        remaining;
    logic               out_valid;
    logic [8*LANES-1:0] out_data;
    logic [LANES-1:0]   out_be;
    logic               pkt_end;
    logic [15:0]        pkt_len;
    logic [5:0]         pkt_type;
    logic [1:0]         pkt_vc;
    logic               fs_pulse;
    logic               fe_pulse;
    logic               trunc_pulse;

    logic               hdr_valid;
    logic [1:0]         hdr_vc;
    logic [5:0]         hdr_dt;
    logic [15:0]        hdr_wc;
    logic [7:0]         ecc_unused;
    logic               hdr_accept;
    logic               last_word;

    mipi_csi_header_assembler #(
        .LANES(LANES)
    ) u_hdr (
        .clk          (clk_i),
        .reset        (reset_i),
        .clear        (!bus.data_valid_i),
        .en           (bus.data_valid_i && state == ST_HDR),
        .data         (bus.data_i),
        .header_valid (hdr_valid),
        .vc           (hdr_vc),
        .dt           (hdr_dt),
        .wc           (hdr_wc),
        .ecc          (ecc_unused)
    );

    assign hdr_accept = DT_ENABLE[hdr_dt] && VC_ENABLE[hdr_vc];
    assign last_word  = remaining <= 16'(LANES);

    // Decoder FSM with registered outputs; valid low aborts any packet
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= ST_HUNT;
            remaining   <= 16'd0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_be      <= '0;
            pkt_end     <= 1'b0;
            pkt_len     <= 16'd0;
            pkt_type    <= 6'd0;
            pkt_vc      <= 2'd0;
            fs_pulse    <= 1'b0;
            fe_pulse    <= 1'b0;
            trunc_pulse <= 1'b0;
        end else if (!bus.data_valid_i) begin
            trunc_pulse <= (state == ST_PAYLOAD) || (state == ST_SKIP);
            state       <= ST_HUNT;
            remaining   <= 16'd0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_be      <= '0;
            pkt_end     <= 1'b0;
            pkt_len     <= 16'd0;
            pkt_type    <= 6'd0;
            pkt_vc      <= 2'd0;
            fs_pulse    <= 1'b0;
            fe_pulse    <= 1'b0;
        end else begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_be      <= '0;
            pkt_end     <= 1'b0;
            fs_pulse    <= 1'b0;
            fe_pulse    <= 1'b0;
            trunc_pulse <= 1'b0;
            unique case (state)
                ST_HUNT: begin
                    if (bus.data_i[7:0] == SYNC_BYTE) begin
                        state <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (hdr_valid) begin
                        state <= ST_HUNT;
                        if (hdr_dt == DT_FS) begin
                            if (VC_ENABLE[hdr_vc]) begin
                                fs_pulse <= 1'b1;
                                pkt_vc   <= hdr_vc;
                            end
                        end else if (hdr_dt == DT_FE) begin
                            if (VC_ENABLE[hdr_vc]) begin
                                fe_pulse <= 1'b1;
                                pkt_vc   <= hdr_vc;
                            end
                        end else if (hdr_dt < DT_LONG_MIN) begin
                            state <= ST_HUNT;
                        end else if (hdr_wc != 16'd0) begin
                            remaining <= hdr_wc;
                            if (hdr_accept) begin
                                pkt_type <= hdr_dt;
                                pkt_len  <= hdr_wc;
                                pkt_vc   <= hdr_vc;
                                state    <= ST_PAYLOAD;
                            end else begin
                                state    <= ST_SKIP;
                            end
                        end
                    end
                end
                ST_PAYLOAD, ST_SKIP: begin
                    if (state == ST_PAYLOAD) begin
                        out_valid <= 1'b1;
                        out_data  <= bus.data_i;
                    end
                    if (last_word) begin
                        out_be    <= (state == ST_PAYLOAD)
                                   ? LANES'(byte_mask(remaining[1:0]))
                                   : '0;
                        pkt_end   <= (state == ST_PAYLOAD);
                        remaining <= 16'd0;
                        state     <= ST_HUNT;
                    end else begin
                        out_be    <= (state == ST_PAYLOAD) ? '1 : '0;
                        remaining <= remaining - 16'(LANES);
                    end
                end
                default: state <= ST_HUNT;
            endcase
        end
    end

    assign bus.output_valid_o  = out_valid;
    assign bus.data_o          = out_data;
    assign bus.byte_en_o       = out_be;
    assign bus.packet_end_o    = pkt_end;
    assign bus.packet_length_o = pkt_len;
    assign bus.packet_type_o   = pkt_type;
    assign bus.vc_o            = pkt_vc;
    assign bus.frame_start_o   = fs_pulse;
    assign bus.frame_end_o     = fe_pulse;
    assign bus.err_truncated_o = trunc_pulse;

endmodule

// File: tb/tb_mipi_csi_packet_decoder_v2.sv
// Directed bench for the CSI-2 packet decoder: a 4-lane instance with
// VC0/VC1 enabled and a 2-lane instance with default filters.
module tb_mipi_csi_packet_decoder_v2;

    logic clk;
    logic rst4;
    logic rst2;
    int   checks;
    int   errors;

    mipi_csi_packet_decoder_v2_if #(.LANES(4)) bus4 ();
    mipi_csi_packet_decoder_v2_if #(.LANES(2)) bus2 ();

    mipi_csi_packet_decoder_v2 #(
        .LANES     (4),
        .VC_ENABLE (4'b0011)
    ) dut4 (
        .clk_i   (clk),
        .reset_i (rst4),
        .bus     (bus4.slave)
    );

    mipi_csi_packet_decoder_v2 #(
        .LANES (2)
    ) dut2 (
        .clk_i   (clk),
        .reset_i (rst2),
        .bus     (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step4(input logic v, input logic [31:0] d);
        bus4.data_valid_i = v;
        bus4.data_i       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic v, input logic [15:0] d);
        bus2.data_valid_i = v;
        bus2.data_i       = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] skipw [4];
        skipw[0] = 32'h11111111;
        skipw[1] = 32'h000000B8;
        skipw[2] = 32'h0000042B;
        skipw[3] = 32'h22222222;
        checks = 0;
        errors = 0;
        rst4 = 1'b1;
        rst2 = 1'b1;
        bus4.data_valid_i = 1'b0;
        bus4.data_i       = '0;
        bus2.data_valid_i = 1'b0;
        bus2.data_i       = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;

        chk("rst4_data", bus4.data_o, 0);
        chk("rst4_ctl", {bus4.output_valid_o, bus4.byte_en_o,
                         bus4.packet_end_o, bus4.packet_length_o,
                         bus4.packet_type_o, bus4.vc_o,
                         bus4.frame_start_o, bus4.frame_end_o,
                         bus4.err_truncated_o}, 0);
        chk("rst2_ctl", {bus2.output_valid_o, bus2.data_o,
                         bus2.byte_en_o, bus2.packet_end_o,
                         bus2.packet_length_o, bus2.packet_type_o,
                         bus2.vc_o, bus2.err_truncated_o}, 0);
        rst4 = 1'b0;
        rst2 = 1'b0;

        // 4 lanes, RAW10 VC0 WC=8
        step4(1, 32'h000000B8);
        chk("t1_sync_ov", bus4.output_valid_o, 0);
        step4(1, 32'hAA00082B);
        chk("t1_hdr_ov", bus4.output_valid_o, 0);
        chk("t1_type", bus4.packet_type_o, 6'h2B);
        chk("t1_len", bus4.packet_length_o, 16'd8);
        chk("t1_vc", bus4.vc_o, 0);
        step4(1, 32'h44332211);
        chk("t1_w1_ov", bus4.output_valid_o, 1);
        chk("t1_w1_data", bus4.data_o, 32'h44332211);
        chk("t1_w1_be", bus4.byte_en_o, 4'hF);
        chk("t1_w1_end", bus4.packet_end_o, 0);
        step4(1, 32'h88776655);
        chk("t1_w2_ov", bus4.output_valid_o, 1);
        chk("t1_w2_data", bus4.data_o, 32'h88776655);
        chk("t1_w2_be", bus4.byte_en_o, 4'hF);
        chk("t1_w2_end", bus4.packet_end_o, 1);
        step4(1, 32'h0000C1C2);
        chk("t1_crc_ov", bus4.output_valid_o, 0);
        chk("t1_crc_end", bus4.packet_end_o, 0);
        chk("t1_type_hold", bus4.packet_type_o, 6'h2B);
        step4(0, 32'h0);
        chk("t1_clr_type", bus4.packet_type_o, 0);
        chk("t1_clr_len", bus4.packet_length_o, 0);

        // Frame start / frame end on VC1
        step4(1, 32'h000000B8);
        step4(1, 32'h00000040);
        chk("fs_pulse", bus4.frame_start_o, 1);
        chk("fs_fe", bus4.frame_end_o, 0);
        chk("fs_vc", bus4.vc_o, 2'd1);
        chk("fs_ov", bus4.output_valid_o, 0);
        step4(1, 32'h000000B8);
        chk("fs_one_cycle", bus4.frame_start_o, 0);
        step4(1, 32'h00000041);
        chk("fe_pulse", bus4.frame_end_o, 1);
        chk("fe_fs", bus4.frame_start_o, 0);
        chk("fe_vc", bus4.vc_o, 2'd1);
        step4(1, 32'h0);
        chk("fe_one_cycle", bus4.frame_end_o, 0);
        chk("fe_ov", bus4.output_valid_o, 0);
        step4(0, 32'h0);

        // RAW10 on disabled VC2, WC=16, sync byte hidden in payload
        step4(1, 32'h000000B8);
        step4(1, 32'h000010AB);
        chk("vc2_hdr_ov", bus4.output_valid_o, 0);
        chk("vc2_no_latch", bus4.packet_length_o, 0);
        for (int i = 0; i < 4; i++) begin
            step4(1, skipw[i]);
            chk("vc2_skip_ov", bus4.output_valid_o, 0);
        end
        step4(1, 32'h0000C3C4);
        chk("vc2_crc_ov", bus4.output_valid_o, 0);
        chk("vc2_type", bus4.packet_type_o, 0);
        step4(1, 32'h000000B8);
        step4(1, 32'h0000042B);
        chk("vc0_type", bus4.packet_type_o, 6'h2B);
        chk("vc0_len", bus4.packet_length_o, 16'd4);
        step4(1, 32'hDDCCBBAA);
        chk("vc0_ov", bus4.output_valid_o, 1);
        chk("vc0_data", bus4.data_o, 32'hDDCCBBAA);
        chk("vc0_be", bus4.byte_en_o, 4'hF);
        chk("vc0_end", bus4.packet_end_o, 1);
        chk("vc0_vc", bus4.vc_o, 0);

        // Valid drops in the middle of a payload
        step4(1, 32'h000000B8);
        step4(1, 32'h0000102B);
        step4(1, 32'h01020304);
        chk("tr_w1_ov", bus4.output_valid_o, 1);
        step4(0, 32'h05060708);
        chk("tr_err", bus4.err_truncated_o, 1);
        chk("tr_ov", bus4.output_valid_o, 0);
        chk("tr_data", bus4.data_o, 0);
        chk("tr_rest", {bus4.byte_en_o, bus4.packet_end_o,
                        bus4.packet_length_o, bus4.packet_type_o,
                        bus4.vc_o}, 0);
        step4(0, 32'h0);
        chk("tr_err_one_cycle", bus4.err_truncated_o, 0);

        // Reset in the middle of a payload
        step4(1, 32'h000000B8);
        step4(1, 32'h0000102B);
        step4(1, 32'h0A0A0A0A);
        chk("rs_w1_ov", bus4.output_valid_o, 1);
        rst4 = 1'b1;
        step4(1, 32'h0B0B0B0B);
        chk("rs_ov", bus4.output_valid_o, 0);
        chk("rs_data", bus4.data_o, 0);
        chk("rs_meta", {bus4.packet_length_o, bus4.packet_type_o,
                        bus4.err_truncated_o}, 0);
        rst4 = 1'b0;

        // RAW8 rejected by the DT filter, then RAW14 accepted
        step4(1, 32'h000000B8);
        step4(1, 32'h0000042A);
        chk("dt8_type", bus4.packet_type_o, 0);
        step4(1, 32'h0D0C0B0A);
        chk("dt8_ov", bus4.output_valid_o, 0);
        step4(1, 32'h0000C5C6);
        chk("dt8_crc_ov", bus4.output_valid_o, 0);
        step4(1, 32'h000000B8);
        step4(1, 32'h0000042D);
        step4(1, 32'h12345678);
        chk("dt14_ov", bus4.output_valid_o, 1);
        chk("dt14_data", bus4.data_o, 32'h12345678);
        chk("dt14_type", bus4.packet_type_o, 6'h2D);
        chk("dt14_end", bus4.packet_end_o, 1);
        step4(0, 32'h0);

        // 2 lanes, RAW12 WC=5
        step2(1, 16'h00B8);
        chk("l2_sync_ov", bus2.output_valid_o, 0);
        step2(1, 16'h052C);
        chk("l2_h1_type", bus2.packet_type_o, 0);
        step2(1, 16'h5A00);
        chk("l2_h2_ov", bus2.output_valid_o, 0);
        chk("l2_type", bus2.packet_type_o, 6'h2C);
        chk("l2_len", bus2.packet_length_o, 16'd5);
        step2(1, 16'hB2B1);
        chk("l2_w1_ov", bus2.output_valid_o, 1);
        chk("l2_w1_data", bus2.data_o, 16'hB2B1);
        chk("l2_w1_be", bus2.byte_en_o, 2'b11);
        chk("l2_w1_end", bus2.packet_end_o, 0);
        step2(1, 16'hB4B3);
        chk("l2_w2_data", bus2.data_o, 16'hB4B3);
        chk("l2_w2_be", bus2.byte_en_o, 2'b11);
        chk("l2_w2_end", bus2.packet_end_o, 0);
        step2(1, 16'hC1B5);
        chk("l2_w3_ov", bus2.output_valid_o, 1);
        chk("l2_w3_data", bus2.data_o, 16'hC1B5);
        chk("l2_w3_be", bus2.byte_en_o, 2'b01);
        chk("l2_w3_end", bus2.packet_end_o, 1);
        step2(1, 16'h00C2);
        chk("l2_crc_ov", bus2.output_valid_o, 0);
        chk("l2_crc_end", bus2.packet_end_o, 0);
        step2(0, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
